prewish5k_mask_loader: RTL and testbench



---
 rtl/prewish5k_mask_loader_pkg.sv | 19 +
 rtl/prewish5k_mask_loader_sync_fifo.sv | 46 ++++
 rtl/prewish5k_mask_loader.sv | 151 +++++++++++++++
 tb/tb_prewish5k_mask_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prewish5k_mask_loader_pkg.sv
// Shared definitions for the prewish5k mask loader: poll FSM states,
// handshake levels used with the debouncer and mentor, entry width helper.
package prewish5k_mask_loader_pkg;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_REQ  = 2'd1,
        P_WAIT = 2'd2
    } poll_state_e;

    localparam logic HS_ASSERT = 1'b1;
    localparam logic HS_IDLE   = 1'b0;

    // FIFO entry is {channel, mask}
    function automatic int entry_w(input int ch_w, input int mask_w);
        return ch_w + mask_w;
    endfunction

endpackage

// File: rtl/prewish5k_mask_loader_sync_fifo.sv
// Synchronous FIFO with extra pointer bit for full/empty; output reads 0 when
// empty so the head can be driven straight onto the consumer bus.
module prewish5k_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is fine when the head leaves in the same cycle
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + CW'(1);
            if (do_pop)  rptr_q <= rptr_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/prewish5k_mask_loader.sv
// Polls the debouncer, turns button rising edges into {channel, DIP mask}
// entries and queues them for the mentor behind a held strobe/ack handshake.
module prewish5k_mask_loader
    import prewish5k_mask_loader_pkg::*;
#(
    parameter  int MASK_W        = 8,
    parameter  int NUM_CH        = 4,
    parameter  int FIFO_DEPTH    = 4,
    parameter  int POLL_DIV_BITS = 4,
    parameter  bit INVERT_DIP    = 1'b1,
    parameter  bit REVERSE_BITS  = 1'b1,
    parameter  int ALIVE_BITS    = 23,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    output logic              DBN_STB_O,
    input  logic              DBN_STB_I,
    input  logic [NUM_CH-1:0] DBN_DAT_I,
    input  logic [MASK_W-1:0] dip_switch,
    output logic              STB_O,
    output logic [MASK_W-1:0] DAT_O,
    output logic [CH_W-1:0]   CH_O,
    input  logic              ACK_I,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overrun,
    output logic              o_alive
);

    localparam int ENTRY_W = entry_w(CH_W, MASK_W);

    // Assertion is immediate; release is delayed through two flops
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    poll_state_e              state_q, state_d;
    logic [POLL_DIV_BITS-1:0] div_q, wcnt_q, wcnt_d;
    logic [NUM_CH-1:0]        btn_q, btn_prev_q, pending_q, pending_d;
    logic [NUM_CH-1:0]        rise, grant_oh, clr;
    logic [CH_W-1:0]          grant_ch;
    logic [MASK_W-1:0]        dip_pol, mask;
    logic [ENTRY_W-1:0]       fifo_dout;
    logic [ALIVE_BITS-1:0]    alive_q;
    logic                     latch, latched_q, overrun_q;
    logic                     push, pop, full, empty;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        DBN_STB_O = HS_IDLE;
        latch     = 1'b0;
        unique case (state_q)
            P_IDLE: if (&div_q) state_d = P_IDLE == P_IDLE ? P_REQ : P_IDLE;
            P_REQ: begin
                DBN_STB_O = HS_ASSERT;
                wcnt_d    = '0;
                state_d   = P_WAIT;
            end
            P_WAIT: begin
                if (DBN_STB_I == HS_ASSERT) begin
                    latch   = 1'b1;
                    state_d = P_IDLE;
                end else if (&wcnt_q) begin
                    state_d = P_IDLE;
                end else begin
                    wcnt_d = wcnt_q + POLL_DIV_BITS'(1);
                end
            end
            default: state_d = P_IDLE;
        endcase
    end

    // Rise is only meaningful in the cycle right after a fresh sample
    assign rise     = latched_q ? (btn_q & ~btn_prev_q) : '0;
    assign grant_oh = pending_q & (~pending_q + NUM_CH'(1));
    assign pop      = ~empty & ACK_I;
    assign push     = (|pending_q) & (~full | pop);
    assign clr      = push ? grant_oh : '0;
    assign pending_d = (pending_q & ~clr) | rise;

    always_comb begin
        grant_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) grant_ch = CH_W'(i);
        end
    end

    always_comb begin
        dip_pol = INVERT_DIP ? ~dip_switch : dip_switch;
        mask    = '0;
        for (int i = 0; i < MASK_W; i++) begin
            mask[i] = REVERSE_BITS ? dip_pol[MASK_W-1-i] : dip_pol[i];
        end
    end

    always_ff @(posedge CLK_I or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= P_IDLE;
            div_q      <= '0;
            wcnt_q     <= '0;
            btn_q      <= '1;
            btn_prev_q <= '1;
            latched_q  <= 1'b0;
            pending_q  <= '0;
            overrun_q  <= 1'b0;
            alive_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_q + POLL_DIV_BITS'(1);
            wcnt_q    <= wcnt_d;
            latched_q <= latch;
            pending_q <= pending_d;
            alive_q   <= alive_q + ALIVE_BITS'(1);
            if (latch) begin
                btn_prev_q <= btn_q;
                btn_q      <= DBN_DAT_I;
            end
            // A press landing on a channel that stays pending is merged
            if (|(rise & pending_q & ~clr)) overrun_q <= 1'b1;
        end
    end

    prewish5k_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK_I),
        .rst_ni  (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({grant_ch, mask}),
        .dout_o  (fifo_dout),
        .count_o (o_count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign STB_O     = ~empty;
    assign DAT_O     = fifo_dout[MASK_W-1:0];
    assign CH_O      = fifo_dout[ENTRY_W-1 -: CH_W];
    assign o_overrun = overrun_q;
    assign o_alive   = alive_q[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish5k_mask_loader.sv
// Randomised bench for prewish5k_mask_loader: a queue-level model of presses
// and deliveries is compared every cycle, plus directed literal checks.
module tb_prewish5k_mask_loader;

    localparam int MASK_W = 8;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;
    localparam int PDB    = 4;
    localparam int AB     = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 3;

    logic              CLK_I = 1'b0;
    logic              RST_I = 1'b0;
    logic              DBN_STB_O;
    logic              DBN_STB_I = 1'b0;
    logic [NUM_CH-1:0] DBN_DAT_I = '0;
    logic [MASK_W-1:0] dip_switch = '0;
    logic              STB_O;
    logic [MASK_W-1:0] DAT_O;
    logic [CH_W-1:0]   CH_O;
    logic              ACK_I = 1'b0;
    logic [CNT_W-1:0]  o_count;
    logic              o_overrun;
    logic              o_alive;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit rand_en = 1'b0;
    bit cmp_en = 1'b0;

    prewish5k_mask_loader #(
        .MASK_W(MASK_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .POLL_DIV_BITS(PDB),
        .INVERT_DIP(1'b1), .REVERSE_BITS(1'b1), .ALIVE_BITS(AB)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .DBN_STB_O(DBN_STB_O), .DBN_STB_I(DBN_STB_I),
        .DBN_DAT_I(DBN_DAT_I), .dip_switch(dip_switch), .STB_O(STB_O), .DAT_O(DAT_O),
        .CH_O(CH_O), .ACK_I(ACK_I), .o_count(o_count), .o_overrun(o_overrun), .o_alive(o_alive)
    );

    always #5 CLK_I = ~CLK_I;
    always @(posedge CLK_I) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [MASK_W-1:0] xform(input logic [MASK_W-1:0] sw);
        logic [MASK_W-1:0] r;
        for (int i = 0; i < MASK_W; i++) r[i] = ~sw[MASK_W-1-i];
        return r;
    endfunction

    // Reference: press events become entries in a queue of pending deliveries
    logic [CH_W+MASK_W-1:0] mq[$];
    logic [NUM_CH-1:0] m_btn, m_pend, m_rise;
    bit m_over;

    always @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            mq.delete();
            m_btn = '1; m_pend = '0; m_rise = '0; m_over = 1'b0;
        end else begin
            if (mq.size() != 0 && ACK_I) void'(mq.pop_front());
            if (m_pend != 0 && mq.size() < DEPTH) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_pend[i]) begin
                        mq.push_back({CH_W'(i), xform(dip_switch)});
                        m_pend[i] = 1'b0;
                        break;
                    end
                end
            end
            if ((m_rise & m_pend) != 0) m_over = 1'b1;
            m_pend = m_pend | m_rise;
            m_rise = '0;
            if (DBN_STB_I) begin
                m_rise = DBN_DAT_I & ~m_btn;
                m_btn  = DBN_DAT_I;
            end
        end
    end

    always @(negedge CLK_I) begin
        if (RST_I && cmp_en) begin
            logic [CH_W+MASK_W-1:0] h;
            h = (mq.size() != 0) ? mq[0] : '0;
            chk("m_stb", STB_O, mq.size() != 0);
            chk("m_dat", DAT_O, h[MASK_W-1:0]);
            chk("m_ch", CH_O, h[CH_W+MASK_W-1 -: CH_W]);
            chk("m_count", o_count, mq.size());
            chk("m_overrun", o_overrun, m_over);
        end
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
        if (rand_en) begin
            ACK_I      = ($urandom_range(0, 3) != 0);
            dip_switch = MASK_W'($urandom);
        end
    endtask

    task automatic poll_resp(input logic [NUM_CH-1:0] val, input int dly);
        int n = 0;
        while (!DBN_STB_O && n < 100) begin tick(); n++; end
        chk("poll_req_seen", DBN_STB_O, 1);
        repeat (dly) tick();
        DBN_STB_I = 1'b1;
        DBN_DAT_I = val;
        tick();
        DBN_STB_I = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pops, k;
        int t[3];
        logic [NUM_CH-1:0] bp[8];
        t = '{0, 0, 0};
        bp = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h7, 4'hF, 4'h7, 4'hF};

        repeat (3) @(posedge CLK_I);
        #1;
        chk("rst_stb", STB_O, 0);
        chk("rst_dat", DAT_O, 0);
        chk("rst_ch", CH_O, 0);
        chk("rst_count", o_count, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_alive", o_alive, 0);
        chk("rst_dbn_stb", DBN_STB_O, 0);
        RST_I = 1'b1;
        cmp_en = 1'b1;

        n = 0;
        while (!o_alive && n < 30) begin tick(); n++; end
        chk("alive_rise", o_alive, 1);
        repeat (7) tick();
        chk("alive_high", o_alive, 1);
        tick();
        chk("alive_low", o_alive, 0);

        // Single press: FE -> inverted 01 -> reversed 80
        dip_switch = 8'hFE;
        ACK_I = 1'b1;
        poll_resp(4'h0, 1);
        poll_resp(4'h1, 2);
        tick();
        chk("single_e1_stb", STB_O, 0);
        tick();
        chk("single_e2_stb", STB_O, 1);
        chk("single_dat", DAT_O, 8'h80);
        chk("single_ch", CH_O, 0);
        tick();
        chk("single_gone", STB_O, 0);

        // Held through reset
        DBN_DAT_I = 4'h2;
        RST_I = 1'b0;
        tick(); tick();
        RST_I = 1'b1;
        poll_resp(4'h2, 1);
        repeat (5) tick();
        chk("held_no_entry", o_count, 0);
        poll_resp(4'h0, 1);
        poll_resp(4'h2, 3);
        tick(); tick();
        chk("held_stb", STB_O, 1);
        chk("held_ch", CH_O, 1);

        // Simultaneous ch0 and ch2
        poll_resp(4'h0, 1);
        poll_resp(4'h5, 1);
        tick(); tick();
        chk("simul_stb0", STB_O, 1);
        chk("simul_ch0", CH_O, 0);
        tick();
        chk("simul_stb1", STB_O, 1);
        chk("simul_ch2", CH_O, 2);
        tick();
        chk("simul_empty", STB_O, 0);

        // Backpressure
        ACK_I = 1'b0;
        poll_resp(4'h0, 1);
        for (int i = 0; i < 8; i++) begin
            dip_switch = MASK_W'($urandom);
            poll_resp(bp[i], $urandom_range(1, 4));
        end
        repeat (4) tick();
        chk("bp_count_full", o_count, 4);
        chk("bp_overrun", o_overrun, 1);
        chk("bp_head_ch", CH_O, 0);
        ACK_I = 1'b1;
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            if (STB_O && ACK_I) pops++;
            tick();
        end
        chk("bp_pops", pops, 5);
        chk("bp_drained", o_count, 0);

        // Ack timeout: requests without acks; latched buttons must not move
        DBN_DAT_I = 4'h0;
        k = 0; n = 0;
        while (k < 3 && n < 200) begin
            tick(); n++;
            if (DBN_STB_O) begin t[k] = cyc; k++; end
        end
        chk("to_seen", k, 3);
        chk("to_period1", t[1] - t[0], 32);
        chk("to_period2", t[2] - t[1], 32);
        poll_resp(4'hF, 1);
        repeat (4) tick();
        chk("to_btn_kept", o_count, 0);

        // Reset mid-operation
        ACK_I = 1'b0;
        poll_resp(4'h0, 1);
        poll_resp(4'h1, 1);
        poll_resp(4'h3, 1);
        poll_resp(4'h7, 1);
        repeat (3) tick();
        chk("mid_count_pre", o_count, 3);
        #2;
        RST_I = 1'b0;
        #1;
        chk("mid_stb", STB_O, 0);
        chk("mid_count", o_count, 0);
        chk("mid_dat", DAT_O, 0);
        chk("mid_ch", CH_O, 0);
        tick(); tick(); tick();
        RST_I = 1'b1;
        repeat (40) tick();
        chk("mid_no_stale", STB_O, 0);

        // Random traffic
        rand_en = 1'b1;
        for (int i = 0; i < 120; i++) poll_resp(NUM_CH'($urandom), $urandom_range(1, 4));
        rand_en = 1'b0;
        ACK_I = 1'b1;
        repeat (20) tick();
        chk("rand_drained", o_count, 0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
